// File: rtl/led_s2p_rx.sv
// Serial-to-parallel receiver for the LED serial link.
// The four link wires are oversampled in the clk domain. Each synchronised
// s_clk rise shifts one bit in, MSB first. A synchronised s_pen rise latches
// the frame onto data_out and raises data_valid for one cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no bits shifted since the last latch or clear (bit_cnt == 0)
// RECV  | frame in progress (0 < bit_cnt < DATA_BITS)
// FULL  | exactly DATA_BITS bits shifted, so a latch now is error-free
// OVER  | more than DATA_BITS bits shifted; the window keeps the newest bits
module led_s2p_rx #(
    parameter int DATA_BITS       = 16,
    parameter int DATA_COUNT_BITS = 5,
    parameter bit INVERT          = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_clk,
    input  logic                 s_dat,
    input  logic                 s_clrn,
    input  logic                 s_pen,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic [7:0]           frame_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        FULL = 2'd2,
        OVER = 2'd3
    } state_t;

    localparam logic [DATA_COUNT_BITS-1:0] CNT_LAST = DATA_COUNT_BITS'(DATA_BITS - 1);
    localparam logic [DATA_COUNT_BITS-1:0] CNT_MAX  = DATA_COUNT_BITS'(DATA_BITS + 1);

    // Pin order in the synchroniser vectors: {s_pen, s_clrn, s_dat, s_clk}.
    logic [3:0] meta;
    logic [3:0] sync;
    logic       clk_prev;
    logic       pen_prev;

    logic       clk_rise;
    logic       pen_rise;
    logic       dat_sync;
    logic       clrn_sync;
    logic       shift;
    logic       latch;

    state_t                 state;
    state_t                 state_post;
    state_t                 state_nxt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic [DATA_BITS-1:0]   shift_post;
    logic [DATA_COUNT_BITS-1:0] bit_cnt;
    logic [DATA_COUNT_BITS-1:0] cnt_post;

    // Two-flop synchroniser for all link wires, plus edge registers for the strobes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta     <= '0;
            sync     <= '0;
            clk_prev <= 1'b0;
            pen_prev <= 1'b0;
        end else begin
            meta     <= {s_pen, s_clrn, s_dat, s_clk};
            sync     <= meta;
            clk_prev <= sync[0];
            pen_prev <= sync[3];
        end
    end

    assign clk_rise  = sync[0] & ~clk_prev;
    assign dat_sync  = sync[1];
    assign clrn_sync = sync[2];
    assign pen_rise  = sync[3] & ~pen_prev;

    // Clear suppresses both shifting and latching.
    assign shift = clk_rise & clrn_sync;
    assign latch = pen_rise & clrn_sync;

    // Post-shift view of the frame; a coincident latch sees this, not the old value.
    always_comb begin
        shift_post = shift_reg;
        cnt_post   = bit_cnt;
        if (shift) begin
            shift_post = {shift_reg[DATA_BITS-2:0], dat_sync};
            if (bit_cnt != CNT_MAX) begin
                cnt_post = bit_cnt + DATA_COUNT_BITS'(1);
            end
        end
    end

    // Next-state logic: state_post is the state after this cycle's shift, before latch/clear.
    always_comb begin
        state_post = state;
        unique case (state)
            IDLE: if (shift) state_post = (bit_cnt == CNT_LAST) ? FULL : RECV;
            RECV: if (shift && (bit_cnt == CNT_LAST)) state_post = FULL;
            FULL: if (shift) state_post = OVER;
            OVER: state_post = OVER;
            default: state_post = IDLE;
        endcase
        state_nxt = state_post;
        if (!clrn_sync || latch) begin
            state_nxt = IDLE;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift window, bit counter and latched outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_reg  <= '0;
            bit_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            frame_cnt  <= 8'd0;
        end else begin
            data_valid <= 1'b0;
            if (!clrn_sync) begin
                shift_reg <= '0;
                bit_cnt   <= '0;
            end else begin
                shift_reg <= shift_post;
                bit_cnt   <= latch ? '0 : cnt_post;
                if (latch) begin
                    data_out   <= INVERT ? ~shift_post : shift_post;
                    data_valid <= 1'b1;
                    frame_err  <= (state_post != FULL);
                    frame_cnt  <= frame_cnt + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_s2p_rx.sv
// Bench for led_s2p_rx: one inverting and one non-inverting instance share
// the same link stimulus; each has its own expected-frame queue and monitor.
module tb_led_s2p_rx;

    localparam int HOLD = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic s_clk = 1'b0;
    logic s_dat = 1'b0;
    logic s_clrn = 1'b1;
    logic s_pen = 1'b0;

    logic [15:0] a_data, b_data;
    logic        a_valid, b_valid, a_err, b_err;
    logic [7:0]  a_cnt, b_cnt;

    int checks = 0;
    int failures = 0;
    logic [7:0] exp_cnt = 8'd0;

    logic [24:0] qa[$];
    logic [24:0] qb[$];

    always #5 clk = ~clk;

    led_s2p_rx #(.DATA_BITS(16), .DATA_COUNT_BITS(5), .INVERT(1'b1)) dut_a (
        .clk(clk), .rst(rst), .s_clk(s_clk), .s_dat(s_dat), .s_clrn(s_clrn), .s_pen(s_pen),
        .data_out(a_data), .data_valid(a_valid), .frame_err(a_err), .frame_cnt(a_cnt)
    );

    led_s2p_rx #(.DATA_BITS(16), .DATA_COUNT_BITS(5), .INVERT(1'b0)) dut_b (
        .clk(clk), .rst(rst), .s_clk(s_clk), .s_dat(s_dat), .s_clrn(s_clrn), .s_pen(s_pen),
        .data_out(b_data), .data_valid(b_valid), .frame_err(b_err), .frame_cnt(b_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Expected frame for both instances: {data_out, frame_err, frame_cnt}.
    task automatic expect_frame(input logic [15:0] v, input logic err);
        exp_cnt = exp_cnt + 8'd1;
        qa.push_back({~v, err, exp_cnt});
        qb.push_back({v, err, exp_cnt});
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        s_clk = 1'b0;
        s_dat = b;
        repeat (HOLD) @(negedge clk);
        s_clk = 1'b1;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic pen_pulse();
        @(negedge clk);
        s_pen = 1'b1;
        repeat (4) @(negedge clk);
        s_pen = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic frame(input logic [31:0] bits, input int n, input logic [15:0] exp_v, input logic err);
        send_bits(bits, n);
        expect_frame(exp_v, err);
        pen_pulse();
    endtask

    // Last s_clk rise and s_pen rise land on the same clk edge.
    task automatic frame_coincident(input logic [15:0] v);
        send_bits({17'd0, v[15:1]}, 15);
        @(negedge clk);
        s_clk = 1'b0;
        s_dat = v[0];
        repeat (HOLD) @(negedge clk);
        expect_frame(v, 1'b0);
        s_clk = 1'b1;
        s_pen = 1'b1;
        repeat (4) @(negedge clk);
        s_pen = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // Monitor for the inverting instance.
    always @(negedge clk) begin
        if (rst && a_valid) begin
            if (qa.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_a unexpected data_valid actual=%h required=none", {a_data, a_err, a_cnt});
            end else begin
                check("frame_a", {7'd0, a_data, a_err, a_cnt}, {7'd0, qa.pop_front()});
            end
        end
    end

    // Monitor for the non-inverting instance.
    always @(negedge clk) begin
        if (rst && b_valid) begin
            if (qb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL frame_b unexpected data_valid actual=%h required=none", {b_data, b_err, b_cnt});
            end else begin
                check("frame_b", {7'd0, b_data, b_err, b_cnt}, {7'd0, qb.pop_front()});
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (5) @(negedge clk);
        check("reset_data", 32'(a_data), 32'h0);
        check("reset_valid", 32'(a_valid), 32'h0);
        check("reset_err", 32'(a_err), 32'h0);
        check("reset_cnt", 32'(a_cnt), 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Nominal frame.
        frame(32'hD52A, 16, 16'hD52A, 1'b0);

        // Reset in the middle of a frame after 7 shifts.
        send_bits(32'h55, 7);
        @(negedge clk);
        check("pre_reset_bitcnt", 32'(dut_a.bit_cnt), 32'd7);
        rst = 1'b0;
        s_clk = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_data_a", 32'(a_data), 32'h0);
        check("midrst_data_b", 32'(b_data), 32'h0);
        check("midrst_valid", 32'(a_valid), 32'h0);
        check("midrst_err", 32'(a_err), 32'h0);
        check("midrst_cnt", 32'(b_cnt), 32'h0);
        check("midrst_bitcnt", 32'(dut_a.bit_cnt), 32'h0);
        check("midrst_state", 32'(dut_a.state), 32'h0);
        check("midrst_shift", 32'(dut_b.shift_reg), 32'h0);
        exp_cnt = 8'd0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        frame(32'hD52A, 16, 16'hD52A, 1'b0);

        // Overrun: 18 bits, last 16 are 0x00FF.
        send_bits(32'h300FF, 18);
        @(negedge clk);
        check("overrun_bitcnt_sat", 32'(dut_a.bit_cnt), 32'd17);
        expect_frame(16'h00FF, 1'b1);
        pen_pulse();
        check("post_latch_bitcnt", 32'(dut_a.bit_cnt), 32'd0);

        // Underrun: 15 bits, window keeps bit 0 of the previous frame.
        frame(32'h1234, 15, 16'h9234, 1'b1);
        frame(32'hA5C3, 16, 16'hA5C3, 1'b0);
        check("err_cleared", 32'(a_err), 32'h0);

        // Clear with a pen rise inside the clear window.
        send_bits(32'hFF, 8);
        @(negedge clk);
        s_clrn = 1'b0;
        @(negedge clk);
        s_pen = 1'b1;
        repeat (3) @(negedge clk);
        s_clrn = 1'b1;
        repeat (3) @(negedge clk);
        s_pen = 1'b0;
        repeat (6) @(negedge clk);
        check("clear_bitcnt", 32'(dut_a.bit_cnt), 32'h0);
        check("clear_shift", 32'(dut_a.shift_reg), 32'h0);
        check("clear_data_a", 32'(a_data), 32'h5A3C);
        check("clear_data_b", 32'(b_data), 32'hA5C3);
        check("clear_cnt", 32'(a_cnt), 32'd4);

        frame_coincident(16'h3C96);

        // Run frames until frame_cnt wraps to 0.
        for (int i = 1; i <= 251; i++) begin
            frame(32'(16'(i * 40503 + 7)), 16, 16'(i * 40503 + 7), 1'b0);
        end

        for (int k = 0; k < 50 && (qa.size() != 0 || qb.size() != 0); k++) @(negedge clk);
        check("queue_a_empty", 32'(qa.size()), 32'd0);
        check("queue_b_empty", 32'(qb.size()), 32'd0);
        check("wrap_cnt_a", 32'(a_cnt), 32'd0);
        check("wrap_cnt_b", 32'(b_cnt), 32'd0);
        check("idle_valid", 32'(a_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
